btn_conditioner: RTL

Per-button input conditioner that sits directly upstream of the LED counter/rate-control logic. It turns raw, bouncing, active-low board pushbuttons into clean, synchronous, single-cycle event strobes: press, release, and auto-repeat while held. It runs on the 27 MHz board clock. The downstream logic consumes `press_pulse` and `repeat_pulse` in place of doing its own edge detection on raw pins.

---
 rtl/btn_conditioner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Per-button conditioner: 2-flop synchronizer, counter debounce, press/release
// strobes and a hold/auto-repeat FSM. One independent channel per button.
module btn_conditioner #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int HOLD_CYCLES     = 13500000,
    parameter int REPEAT_CYCLES   = 2700000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_BTN-1:0] pressed,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_T   = TW'(HOLD_CYCLES);
    localparam logic [TW-1:0] REPEAT_T = TW'(REPEAT_CYCLES);
    localparam logic [TW-1:0] T_ONE    = TW'(1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } hold_state_t;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic          s1, s2, stable;
        logic [DW-1:0] db_cnt;
        logic          accept, press_acc, release_acc;
        logic          pressed_r, press_r, release_r, repeat_r;
        hold_state_t   state, state_nxt;
        logic [TW-1:0] timer, timer_nxt;
        logic          repeat_nxt;

        assign accept      = (s2 != stable) && (db_cnt == DB_MAX);
        assign press_acc   = accept && stable;
        assign release_acc = accept && !stable;

        // Level and strobes are registered on the same edge that flips stable.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1        <= 1'b1;
                s2        <= 1'b1;
                stable    <= 1'b1;
                db_cnt    <= '0;
                pressed_r <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                s1        <= btn_n[i];
                s2        <= s1;
                press_r   <= press_acc;
                release_r <= release_acc;
                if (s2 == stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_MAX) begin
                    stable    <= s2;
                    pressed_r <= ~s2;
                    db_cnt    <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state    <= IDLE;
                timer    <= '0;
                repeat_r <= 1'b0;
            end else begin
                state    <= state_nxt;
                timer    <= timer_nxt;
                repeat_r <= repeat_nxt;
            end
        end

        // Release is checked first so it always wins over a coincident repeat tick.
        always_comb begin
            state_nxt  = state;
            timer_nxt  = timer;
            repeat_nxt = 1'b0;
            case (state)
                IDLE: begin
                    if (press_acc) begin
                        state_nxt = HOLD;
                        timer_nxt = T_ONE;
                    end
                end
                HOLD: begin
                    if (release_acc) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else if (timer == HOLD_T) begin
                        state_nxt  = REPEAT;
                        timer_nxt  = T_ONE;
                        repeat_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (release_acc) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else if (timer == REPEAT_T) begin
                        timer_nxt  = T_ONE;
                        repeat_nxt = 1'b1;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end
            endcase
        end

        assign pressed[i]       = pressed_r;
        assign press_pulse[i]   = press_r;
        assign release_pulse[i] = release_r;
        assign repeat_pulse[i]  = repeat_r;
    end

endmodule
